// File: rtl/move_executor.sv
// move_executor: owns the checkers board; runs select, move, jump,
// capture, promotion and turn counting for the active player.
// Ports: clk, rst (async, active-low), sel_pulse, cursor_loc, legal_move
//   in; serialized_board, select_loc, piece_selected, turn, turn_count,
//   busy out (all registered).
// Optional: define MULTI_JUMP_EN to chain further captures in one turn.
module move_executor #(
  parameter int SETTLE_CYCLES = 2,
  parameter int TURN_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel_pulse,
  input  logic [5:0]            cursor_loc,
  input  logic [27:0]           legal_move,
  output logic [191:0]          serialized_board,
  output logic [5:0]            select_loc,
  output logic                  piece_selected,
  output logic                  turn,
  output logic [TURN_CNT_W-1:0] turn_count,
  output logic                  busy
);

  localparam logic [2:0] EMPTY    = 3'b000;
  localparam logic [2:0] RED_MAN  = 3'b001;
  localparam logic [2:0] RED_KING = 3'b010;
  localparam logic [2:0] BLK_MAN  = 3'b011;
  localparam logic [2:0] BLK_KING = 3'b100;

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SELECTED,
    S_MOVE,
    S_COMMIT
`ifdef MULTI_JUMP_EN
    ,
    S_CHAIN_CHK,
    S_CHAIN_SEL
`endif
  } state_t;

  function automatic logic [191:0] init_board();
    logic [191:0] b;
    b = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if ((r + c) % 2 == 1) begin
          if (r <= 2)
            b[3*(r*8+c) +: 3] = BLK_MAN;
          else if (r >= 5)
            b[3*(r*8+c) +: 3] = RED_MAN;
        end
      end
    end
    return b;
  endfunction

  localparam logic [191:0] INIT_BOARD = init_board();

  function automatic logic [2:0] sq(
    input logic [191:0] b,
    input logic [5:0]   i
  );
    return b[3*int'(i) +: 3];
  endfunction

  function automatic logic own(
    input logic [2:0] code,
    input logic       t
  );
    if (t)
      return (code == BLK_MAN) || (code == BLK_KING);
    return (code == RED_MAN) || (code == RED_KING);
  endfunction

  // Rows exactly two apart, i.e. the move is a jump.
  function automatic logic row_gap2(
    input logic [5:0] a,
    input logic [5:0] b
  );
    logic [3:0] ra;
    logic [3:0] rb;
    ra = {1'b0, a[5:3]};
    rb = {1'b0, b[5:3]};
    return (ra - rb == 4'd2) || (rb - ra == 4'd2);
  endfunction

  state_t                state_q, state_d;
  logic [191:0]          board_q, board_d;
  logic [5:0]            sel_q, sel_d;
  logic [5:0]            dst_q, dst_d;
  logic                  psel_q, psel_d;
  logic                  turn_q, turn_d;
  logic [TURN_CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic                  busy_q, busy_d;

  logic [2:0] cur_code;
  logic [2:0] src_code;
  logic [2:0] mv_code;
  logic [5:0] mid;
  logic       hit;
  logic       jump;
  logic       promo;
`ifdef MULTI_JUMP_EN
  logic       chain_hit;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      board_q  <= INIT_BOARD;
      sel_q    <= '0;
      dst_q    <= '0;
      psel_q   <= 1'b0;
      turn_q   <= 1'b0;
      cnt_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      sel_q    <= sel_d;
      dst_q    <= dst_d;
      psel_q   <= psel_d;
      turn_q   <= turn_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    cur_code = sq(board_q, cursor_loc);
    src_code = sq(board_q, sel_q);
    hit      = 1'b0;
`ifdef MULTI_JUMP_EN
    chain_hit = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (legal_move[7*k+6] &&
          legal_move[7*k +: 6] == cursor_loc)
        hit = 1'b1;
`ifdef MULTI_JUMP_EN
      if (legal_move[7*k+6] &&
          row_gap2(legal_move[7*k +: 6], sel_q))
        chain_hit = 1'b1;
`endif
    end

    mv_code = src_code;
    if (src_code == RED_MAN && dst_q[5:3] == 3'd0)
      mv_code = RED_KING;
    if (src_code == BLK_MAN && dst_q[5:3] == 3'd7)
      mv_code = BLK_KING;
    promo = (mv_code != src_code);
    jump  = row_gap2(sel_q, dst_q);
    mid   = 6'(({1'b0, sel_q} + {1'b0, dst_q}) >> 1);
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    sel_d    = sel_q;
    dst_d    = dst_q;
    psel_d   = psel_q;
    turn_d   = turn_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;

    unique case (state_q)
      S_IDLE: begin
        if (sel_pulse && own(cur_code, turn_q)) begin
          sel_d    = cursor_loc;
          psel_d   = 1'b1;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end

      // Give game_logic time to recompute legal_move
      // for the new select_loc.
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST)
          state_d = S_SELECTED;
        else
          settle_d = settle_q + 1'b1;
      end

      S_SELECTED: begin
        if (sel_pulse) begin
          if (cursor_loc == sel_q) begin
            psel_d  = 1'b0;
            state_d = S_IDLE;
          end else if (hit) begin
            dst_d   = cursor_loc;
            state_d = S_MOVE;
          end else if (own(cur_code, turn_q)) begin
            sel_d    = cursor_loc;
            settle_d = '0;
            state_d  = S_SETTLE;
          end
        end
      end

      // Destination written last so it wins over
      // the source/capture clears.
      S_MOVE: begin
        board_d[3*int'(sel_q) +: 3] = EMPTY;
        if (jump)
          board_d[3*int'(mid) +: 3] = EMPTY;
        board_d[3*int'(dst_q) +: 3] = mv_code;
        state_d = S_COMMIT;
`ifdef MULTI_JUMP_EN
        if (jump && !promo) begin
          sel_d    = dst_q;
          settle_d = '0;
          state_d  = S_CHAIN_CHK;
        end
`endif
      end

      S_COMMIT: begin
        turn_d  = ~turn_q;
        if (!(&cnt_q))
          cnt_d = cnt_q + 1'b1;
        psel_d  = 1'b0;
        state_d = S_IDLE;
      end

`ifdef MULTI_JUMP_EN
      S_CHAIN_CHK: begin
        if (settle_q == SETTLE_LAST)
          state_d = chain_hit ? S_CHAIN_SEL : S_COMMIT;
        else
          settle_d = settle_q + 1'b1;
      end

      // Only a further jump is accepted; no deselect
      // or reselect mid-chain.
      S_CHAIN_SEL: begin
        if (sel_pulse && hit &&
            row_gap2(cursor_loc, sel_q)) begin
          dst_d   = cursor_loc;
          state_d = S_MOVE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = 1'b0;
    unique case (state_d)
      S_SETTLE,
      S_MOVE,
`ifdef MULTI_JUMP_EN
      S_CHAIN_CHK,
`endif
      S_COMMIT: busy_d = 1'b1;
      default:  busy_d = 1'b0;
    endcase
  end

  assign serialized_board = board_q;
  assign select_loc       = sel_q;
  assign piece_selected   = psel_q;
  assign turn             = turn_q;
  assign turn_count       = cnt_q;
  assign busy             = busy_q;

  // promo is consumed only by the chain logic.
`ifndef MULTI_JUMP_EN
  logic unused_promo;
  assign unused_promo = promo;
`endif

endmodule
